ibex_custom_modvec: RTL
=======================

IBEX_CUSTOM_MODVEC -- requirements
Module: ibex_custom_modvec

Interface
REQ-001 SHALL have parameter NUM_LANES, default 3: number of RAM words fetched and reduced modulo the divisor (1..8).
REQ-002 SHALL have parameter DATA_W, default 32: operand, remainder and result width.
REQ-003 SHALL have parameter ADDR_W, default 14: RAM word-address width.
REQ-004 SHALL have port clk_i  in  1: sole clock; one clock, all state on its rising edge.
REQ-005 SHALL have port rst_i  in  1: reset, synchronous, active-high.
REQ-006 SHALL have port en_i  in  1: custom instruction present in EX; held high until valid_o or flush.
REQ-007 SHALL have port op_i  in  5: custom opcode (custom_op_e).
REQ-008 SHALL have port base_addr_i  in  32: byte address from RS1; word address = base_addr_i[ADDR_W+1:2].
REQ-009 SHALL have port divisor_i  in  DATA_W: divisor from RS2.
REQ-010 SHALL have port ram_addr_o  out  ADDR_W: RAM read word address.
REQ-011 SHALL have port ram_rd_o  out  1: RAM read strobe.
REQ-012 SHALL have port ram_data_i  in  DATA_W: RAM read data, valid one cycle after the strobed address.
REQ-013 SHALL have port result_o  out  DATA_W: reduced result to regfile write mux.
REQ-014 SHALL have port busy_o  out  1: state not IDLE.
REQ-015 SHALL have port valid_o  out  1: one-cycle pulse, result_o valid (drives ex_valid_o when custom).

Function
REQ-016 SHALL implement states IDLE, FETCH, CALC, REDUCE, DONE.
REQ-017 SHALL, in IDLE with en_i=1 (accept cycle 0), latch op_i, divisor_i and word base address, clear fetch counter, go to FETCH.
REQ-018 SHALL, in FETCH counter k=0..NUM_LANES-1, drive ram_rd_o=1, ram_addr_o=(base+k) mod 2^ADDR_W; capture ram_data_i into lane k-1 register at k>=1.
REQ-019 SHALL, at k=NUM_LANES, capture lane NUM_LANES-1, drop ram_rd_o, start all lanes, go to CALC (FETCH lasts NUM_LANES+1 cycles).
REQ-020 SHALL compute each lane remainder unsigned with a restoring shift-subtract taking exactly DATA_W cycles, all lanes in lockstep.
REQ-021 SHALL yield remainder = dividend when divisor is 0 (RISC-V REMU convention), same latency.
REQ-022 SHALL, in REDUCE (1 cycle), combine remainders: MODOP_SUM = sum truncated to DATA_W; MODOP_MAX = unsigned maximum; MODOP_XOR = bitwise xor.
REQ-023 SHALL, in DONE, assert valid_o for exactly one cycle and hold result_o; next state IDLE.
REQ-024 SHALL assert valid_o exactly NUM_LANES+DATA_W+3 cycles after accept (38 at defaults).
REQ-025 SHALL, for an op outside custom_op_e, skip FETCH/CALC, go to DONE with result_o=0 (valid at cycle 1).
REQ-026 SHALL abort on en_i=0 in any non-IDLE, non-DONE state: IDLE next cycle, no valid_o, ram_rd_o=0 that cycle.
REQ-027 SHALL accept a new operation in the IDLE cycle immediately following DONE if en_i=1 (back-to-back).
REQ-028 SHALL ignore op_i, base_addr_i, divisor_i changes after accept.
REQ-029 SHALL drive ram_addr_o=0, ram_rd_o=0 outside FETCH issue cycles.

Reset
REQ-030 SHALL, on rst_i=1 at a clock edge, from any state including mid-operation, go to IDLE; valid_o=0, busy_o=0, ram_rd_o=0, ram_addr_o=0, result_o=0, lane registers and counters 0.

Structure
REQ-031 SHALL place custom_op_e (MODOP_SUM=5'd8, MODOP_MAX=5'd9, MODOP_XOR=5'd10) and the state enum in ibex_pkg.
REQ-032 SHALL instantiate NUM_LANES copies of sub-module ibex_custom_rem_lane (start, dividend, divisor -> remainder, done) via generate loop.

Verification
REQ-033 SHALL cover: RAM[0x10..0x12]={100,7,23}, base 0x40, divisor 10, SUM -> result_o=10, valid_o at cycle 38 only.
REQ-034 SHALL cover: same data, MAX -> 7; XOR -> 0^7^3=4.
REQ-035 SHALL cover: divisor 0, SUM -> 130; divisor 0xFFFFFFFF with data 0xFFFFFFFF -> lane remainder 0.
REQ-036 SHALL cover: base word 0x3FFF -> ram_addr_o sequence 0x3FFF, 0x0000, 0x0001.
REQ-037 SHALL cover: en_i dropped at cycle 10 -> no valid_o, busy_o=0 at cycle 11; next op returns correct result; rst_i at cycle 20 likewise -> all outputs 0.
REQ-038 SHALL cover: two back-to-back SUM ops, second accepted cycle after first valid_o -> both results correct, valid_o at cycles 38 and 77.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared types for the modular-vector custom instruction unit.
// Opcode encodings, FSM states and opcode validity check.
package ibex_pkg;

    typedef enum logic [4:0] {
        MODOP_SUM = 5'd8,
        MODOP_MAX = 5'd9,
        MODOP_XOR = 5'd10
    } custom_op_e;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CALC,
        REDUCE,
        DONE
    } modvec_state_e;

    function automatic logic is_modop(input logic [4:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            MODOP_SUM, MODOP_MAX, MODOP_XOR: ok = 1'b1;
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ibex_custom_rem_lane.sv
// Unsigned remainder lane: restoring shift-subtract, one quotient bit per cycle.
// Latency: DATA_W cycles after start_i; done_o marks the cycle whose edge lands the final remainder.
// No backpressure: a start_i pulse always reloads and restarts the lane.
module ibex_custom_rem_lane
    import ibex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] remainder_o,
    output logic              done_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] dvd_q;
    logic [DATA_W-1:0] dsr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              active_q;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;

    // A zero divisor never subtracts anything, so the dividend shifts straight
    // into the remainder: REMU semantics with no special case.
    assign shifted = {rem_q, dvd_q[DATA_W-1]};
    assign trial   = shifted - {1'b0, dsr_q};

    assign done_o      = active_q && (cnt_q == CNT_W'(DATA_W - 1));
    assign remainder_o = rem_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            rem_q    <= '0;
            dvd_q    <= dividend_i;
            dsr_q    <= divisor_i;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            dvd_q <= dvd_q << 1;
            rem_q <= trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ibex_custom_modvec.sv
// Custom instruction: fetch NUM_LANES RAM words, reduce each modulo RS2, combine (sum/max/xor).
// Latency: valid_o NUM_LANES+DATA_W+3 cycles after accept; unknown opcode answers 0 one cycle after accept.
// No backpressure: en_i must stay high until valid_o; dropping it aborts to IDLE with no result.
module ibex_custom_modvec
    import ibex_pkg::*;
#(
    parameter int NUM_LANES = 3,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 14
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [4:0]        op_i,
    input  logic [31:0]       base_addr_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_rd_o,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic [DATA_W-1:0] result_o,
    output logic              busy_o,
    output logic              valid_o
);

    localparam int CNT_W = $clog2(NUM_LANES + 1);

    modvec_state_e     state_q, state_d;
    logic [4:0]        op_q;
    logic [DATA_W-1:0] div_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  k_q;
    logic [DATA_W-1:0] lane_q   [NUM_LANES];
    logic [DATA_W-1:0] lane_rem [NUM_LANES];
    logic [NUM_LANES-1:0] lane_done;
    logic [DATA_W-1:0] combined;
    logic              fetch_issue;
    logic              fetch_last;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{base_addr_i[31:ADDR_W+2], base_addr_i[1:0]};

    assign fetch_issue = (state_q == FETCH) && en_i && (k_q < CNT_W'(NUM_LANES));
    assign fetch_last  = (state_q == FETCH) && en_i && (k_q == CNT_W'(NUM_LANES));

    assign ram_rd_o   = fetch_issue;
    assign ram_addr_o = fetch_issue ? base_q + ADDR_W'(k_q) : '0;
    assign busy_o     = (state_q != IDLE);
    assign valid_o    = (state_q == DONE);

    // The last lane's word arrives on the very cycle the lanes start, so it
    // bypasses its capture register.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [DATA_W-1:0] dividend;
        if (i == NUM_LANES - 1) begin : g_last
            assign dividend = ram_data_i;
        end else begin : g_mid
            assign dividend = lane_q[i];
        end

        ibex_custom_rem_lane #(
            .DATA_W(DATA_W)
        ) u_lane (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .start_i    (fetch_last),
            .dividend_i (dividend),
            .divisor_i  (div_q),
            .remainder_o(lane_rem[i]),
            .done_o     (lane_done[i])
        );
    end

    always_comb begin
        combined = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            case (op_q)
                MODOP_SUM: combined = combined + lane_rem[i];
                MODOP_MAX: if (lane_rem[i] > combined) combined = lane_rem[i];
                MODOP_XOR: combined = combined ^ lane_rem[i];
                default:   combined = combined;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en_i) state_d = is_modop(op_i) ? FETCH : DONE;
            FETCH:   if (!en_i) state_d = IDLE;
                     else if (k_q == CNT_W'(NUM_LANES)) state_d = CALC;
            CALC:    if (!en_i) state_d = IDLE;
                     else if (&lane_done) state_d = REDUCE;
            REDUCE:  state_d = en_i ? DONE : IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q     <= '0;
            div_q    <= '0;
            base_q   <= '0;
            k_q      <= '0;
            result_o <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: if (en_i) begin
                    op_q   <= op_i;
                    div_q  <= divisor_i;
                    base_q <= base_addr_i[ADDR_W+1:2];
                    k_q    <= '0;
                    if (!is_modop(op_i)) result_o <= '0;
                end
                FETCH: if (en_i) begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (k_q == CNT_W'(i + 1)) lane_q[i] <= ram_data_i;
                    end
                    k_q <= k_q + 1'b1;
                end
                REDUCE: if (en_i) result_o <= combined;
                default: ;
            endcase
        end
    end

endmodule
